// File: rtl/param_stream_tx.sv
// param_stream_tx: captures a parallel parameter image and streams it
// out byte by byte over a valid/ready handshake with a running checksum.
module param_stream_tx #(
   parameter int NUM_BYTES = 24,
   parameter int DW        = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [NUM_BYTES*DW-1:0] params_in,
   input  logic                    tx_ready,
   output logic [DW-1:0]           data_out,
   output logic [1:0]              selector,
   output logic                    tx_valid,
   output logic                    tx_last,
   output logic                    busy,
   output logic                    done,
   output logic [DW-1:0]           checksum
);

   localparam int IW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam logic [IW-1:0] LAST = IW'(NUM_BYTES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [NUM_BYTES*DW-1:0] frame;
   logic [IW-1:0]           idx;
   logic                    xfer;
   logic                    accept;

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state and handshake outputs
   always_comb begin
      state_nxt = state;
      tx_valid  = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      tx_last   = 1'b0;
      data_out  = '0;
      xfer      = 1'b0;
      accept    = 1'b0;
      selector  = 2'b00;
      unique case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = SEND;
            end
         end
         SEND: begin
            tx_valid = 1'b1;
            busy     = 1'b1;
            tx_last  = (idx == LAST);
            data_out = frame[DW*int'(idx) +: DW];
            xfer     = tx_ready;
            if (xfer) begin
               selector = 2'b01;
               if (tx_last) begin
                  state_nxt = DONE;
               end
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // frame capture, byte index and running checksum
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         frame    <= '0;
         idx      <= '0;
         checksum <= '0;
      end else if (accept) begin
         frame    <= params_in;
         idx      <= '0;
         checksum <= '0;
      end else if (xfer) begin
         checksum <= checksum + data_out;
         if (!tx_last) begin
            idx <= idx + IW'(1);
         end
      end
   end

endmodule

// File: tb/tb_param_stream_tx.sv
// tb_param_stream_tx: directed and randomized frames against a
// byte-list reference model of the parameter streamer.
module tb_param_stream_tx;

   localparam int N  = 24;
   localparam int DW = 8;

   logic            clk = 1'b0;
   logic            reset;
   logic            start;
   logic [N*DW-1:0] params_in;
   logic            tx_ready;
   logic [DW-1:0]   data_out;
   logic [1:0]      selector;
   logic            tx_valid;
   logic            tx_last;
   logic            busy;
   logic            done;
   logic [DW-1:0]   checksum;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   param_stream_tx #(.NUM_BYTES(N), .DW(DW)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .params_in (params_in),
      .tx_ready  (tx_ready),
      .data_out  (data_out),
      .selector  (selector),
      .tx_valid  (tx_valid),
      .tx_last   (tx_last),
      .busy      (busy),
      .done      (done),
      .checksum  (checksum)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_quiet(input string tag, input logic [DW-1:0] sum);
      check({tag, ".tx_valid"}, tx_valid, 0);
      check({tag, ".busy"}, busy, 0);
      check({tag, ".done"}, done, 0);
      check({tag, ".tx_last"}, tx_last, 0);
      check({tag, ".data_out"}, data_out, 0);
      check({tag, ".selector"}, selector, 0);
      check({tag, ".checksum"}, checksum, sum);
   endtask

   function automatic logic [N*DW-1:0] ramp_img();
      logic [N*DW-1:0] img;
      for (int i = 0; i < N; i++) img[i*DW +: DW] = DW'(i + 1);
      return img;
   endfunction

   function automatic logic [N*DW-1:0] rand_img();
      logic [N*DW-1:0] img;
      for (int i = 0; i < N; i++) img[i*DW +: DW] = DW'($urandom);
      return img;
   endfunction

   function automatic logic [N*DW-1:0] fill_img(input logic [DW-1:0] b);
      logic [N*DW-1:0] img;
      for (int i = 0; i < N; i++) img[i*DW +: DW] = b;
      return img;
   endfunction

   // mode: 0 ready=1, 1 toggling, 2 random, 3 stall 3 cycles at byte 5
   task automatic run_frame(input logic [N*DW-1:0] img, input int mode,
                            input bit perturb, input int abort_at,
                            input string tag);
      logic [DW-1:0] q[$];
      logic [DW-1:0] sum;
      logic          r;
      int            k;
      int            cyc;
      int            stalls;
      sum    = '0;
      k      = 0;
      cyc    = 0;
      stalls = 0;
      for (int i = 0; i < N; i++) q.push_back(img[i*DW +: DW]);
      @(posedge clk); #1;
      params_in = img;
      start     = 1'b1;
      tx_ready  = 1'($urandom);
      @(negedge clk);
      check({tag, ".pre_busy"}, busy, 0);
      @(posedge clk); #1;
      start = 1'b0;
      if (perturb) params_in = rand_img();
      while (k < N && cyc < 200) begin
         case (mode)
            0:       r = 1'b1;
            1:       r = (cyc % 2 == 0);
            2:       r = 1'($urandom_range(0, 1));
            default: begin
               r = !(k == 5 && stalls < 3);
               if (!r) stalls++;
            end
         endcase
         tx_ready = r;
         if (perturb) begin
            start     = (cyc == 3);
            params_in = rand_img();
         end
         @(negedge clk);
         check({tag, ".tx_valid"}, tx_valid, 1);
         check({tag, ".busy"}, busy, 1);
         check({tag, ".done"}, done, 0);
         check({tag, ".data_out"}, data_out, q[k]);
         check({tag, ".tx_last"}, tx_last, (k == N - 1));
         check({tag, ".selector"}, selector, r ? 2'b01 : 2'b00);
         if (abort_at == k) return;
         if (r) begin
            sum = sum + q[k];
            k++;
         end
         cyc++;
         @(posedge clk); #1;
      end
      check({tag, ".bytes_sent"}, k, N);
      if (mode == 0) check({tag, ".latency"}, cyc, N);
      start    = perturb;
      tx_ready = 1'($urandom);
      @(negedge clk);
      check({tag, ".done_pulse"}, done, 1);
      check({tag, ".done_busy"}, busy, 0);
      check({tag, ".done_valid"}, tx_valid, 0);
      check({tag, ".done_data"}, data_out, 0);
      check({tag, ".done_sel"}, selector, 0);
      check({tag, ".done_sum"}, checksum, sum);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check_quiet({tag, ".idle1"}, sum);
      @(negedge clk);
      check_quiet({tag, ".idle2"}, sum);
   endtask

   initial begin
      reset     = 1'b0;
      start     = 1'b1;
      tx_ready  = 1'b1;
      params_in = rand_img();
      #1;
      check_quiet("rst0", 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         start     = 1'($urandom);
         tx_ready  = 1'($urandom);
         params_in = rand_img();
         #1;
         check_quiet("rst_hold", 0);
      end
      @(negedge clk);
      start  = 1'b0;
      reset  = 1'b1;

      run_frame(ramp_img(), 0, 1'b0, -1, "ramp");
      check("ramp.sum_const", checksum, 8'h2C);

      run_frame(ramp_img(), 3, 1'b0, -1, "stall");
      check("stall.sum_const", checksum, 8'h2C);

      run_frame(ramp_img(), 2, 1'b1, -1, "perturb");
      check("perturb.sum_const", checksum, 8'h2C);

      run_frame(ramp_img(), 0, 1'b0, 10, "abort");
      #2;
      reset = 1'b0;
      #1;
      check_quiet("abort_rst", 0);
      @(negedge clk);
      check_quiet("abort_rst_hold", 0);
      reset = 1'b1;
      run_frame(ramp_img(), 0, 1'b0, -1, "restart");

      run_frame(fill_img(8'hFF), 1, 1'b0, -1, "ones");
      check("ones.sum_const", checksum, 8'hE8);

      for (int t = 0; t < 3; t++) begin
         run_frame(rand_img(), 2, 1'($urandom), -1, "random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
